fcc_ground_seg: RTL and testbench

//  Ground-segmentation stage directly upstream of fcc_top. Consumes the raw

---
 rtl/fcc_ground_seg.sv | 192 +++++++++++++++++++
 tb/tb_fcc_ground_seg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcc_ground_seg.sv
// fcc_ground_seg: tags each range-image point as ground/obstacle before it
// reaches fcc_top. The tag combines an absolute height limit with a
// vertical slope check against the previous row's z in the same column.
// The point itself passes through unchanged in a single output register.
// Optional macro FCC_GSEG_STATS_EN enables the per-frame ground_cnt counter.
// When the macro is undefined, ground_cnt is tied to 0.
module fcc_ground_seg #(
  parameter int W        = 16,
  parameter int ROWS     = 30,
  parameter int COLS     = 30,
  parameter int COL_W    = 5,
  parameter int Z_MAX    = 12,
  parameter int SLOPE_TH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7:0]          s_row,
  input  logic [COL_W-1:0]    s_col,
  input  logic signed [W-1:0] s_x,
  input  logic signed [W-1:0] s_y,
  input  logic signed [W-1:0] s_z,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [7:0]          m_row,
  output logic [COL_W-1:0]    m_col,
  output logic signed [W-1:0] m_x,
  output logic signed [W-1:0] m_y,
  output logic signed [W-1:0] m_z,
  output logic                m_is_ground,
  output logic                frame_done,
  output logic                bad_idx,
  output logic [15:0]         ground_cnt
);

  localparam int                DEPTH    = 1 << COL_W;
  localparam logic signed [W-1:0] Z_MAX_S  = W'(Z_MAX);
  localparam logic [W:0]        SLOPE_S  = (W+1)'(SLOPE_TH);
  localparam logic [COL_W:0]    COLS_EXT = (COL_W+1)'(COLS);
  localparam logic [7:0]        LAST_ROW = 8'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);

  // |a - b| evaluated in W+1 bits so the difference can never wrap
  function automatic logic [W:0] abs_diff(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
    logic signed [W:0] d;
    d = {a[W-1], a} - {b[W-1], b};
    return d[W] ? -d : d;
  endfunction

  logic                accept;
  logic                is_empty, in_range, row0, ground;
  logic [W:0]          slope;

  logic                m_valid_q, m_valid_d;
  logic [7:0]          m_row_q, m_row_d;
  logic [COL_W-1:0]    m_col_q, m_col_d;
  logic signed [W-1:0] m_x_q, m_x_d, m_y_q, m_y_d, m_z_q, m_z_d;
  logic                m_gnd_q, m_gnd_d;
  logic                frame_done_q, frame_done_d;
  logic                bad_idx_q, bad_idx_d;
  logic signed [W-1:0] zbuf_q [DEPTH];
  logic signed [W-1:0] zbuf_d [DEPTH];
  logic [DEPTH-1:0]    zbuf_v_q, zbuf_v_d;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // Classify the incoming point against the height limit and line buffer
  always_comb begin
    is_empty = (s_x == '0) && (s_y == '0) && (s_z == '0);
    in_range = ({1'b0, s_col} < COLS_EXT);
    row0     = (s_row == 8'd0);
    slope    = abs_diff(s_z, zbuf_q[s_col]);
    if (is_empty || !in_range)           ground = 1'b1;
    else if (s_z > Z_MAX_S)              ground = 1'b0;
    else if (row0 || !zbuf_v_q[s_col])   ground = 1'b1;
    else                                 ground = (slope <= SLOPE_S);
  end

  // Output register, sticky error flag, frame-end detection
  always_comb begin
    m_valid_d = m_valid_q;
    m_row_d   = m_row_q;
    m_col_d   = m_col_q;
    m_x_d     = m_x_q;
    m_y_d     = m_y_q;
    m_z_d     = m_z_q;
    m_gnd_d   = m_gnd_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_row_d   = s_row;
      m_col_d   = s_col;
      m_x_d     = s_x;
      m_y_d     = s_y;
      m_z_d     = s_z;
      m_gnd_d   = ground;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
    bad_idx_d    = bad_idx_q | (accept && !in_range);
    frame_done_d = m_valid_q && m_ready && (m_row_q == LAST_ROW) && (m_col_q == LAST_COL);
  end

  // Line buffer update: row 0 starts a new frame, so an empty row-0 return
  // still invalidates its column rather than leaving last frame's z behind
  always_comb begin
    zbuf_d   = zbuf_q;
    zbuf_v_d = zbuf_v_q;
    if (accept && in_range) begin
      if (!is_empty) begin
        zbuf_d[s_col]   = s_z;
        zbuf_v_d[s_col] = 1'b1;
      end else if (row0) begin
        zbuf_v_d[s_col] = 1'b0;
      end
    end
  end

  // Control and output state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_row_q      <= '0;
      m_col_q      <= '0;
      m_x_q        <= '0;
      m_y_q        <= '0;
      m_z_q        <= '0;
      m_gnd_q      <= 1'b0;
      frame_done_q <= 1'b0;
      bad_idx_q    <= 1'b0;
      zbuf_v_q     <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_row_q      <= m_row_d;
      m_col_q      <= m_col_d;
      m_x_q        <= m_x_d;
      m_y_q        <= m_y_d;
      m_z_q        <= m_z_d;
      m_gnd_q      <= m_gnd_d;
      frame_done_q <= frame_done_d;
      bad_idx_q    <= bad_idx_d;
      zbuf_v_q     <= zbuf_v_d;
    end
  end

  // z line-buffer storage; contents are qualified by zbuf_v_q
  always_ff @(posedge clk) begin
    zbuf_q <= zbuf_d;
  end

`ifdef FCC_GSEG_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] ground_cnt_q, ground_cnt_d;

  // Per-frame ground count; the (0,0) point restarts it
  always_comb begin
    ground_cnt_d = ground_cnt_q;
    if (accept) begin
      if (row0 && (s_col == '0))
        ground_cnt_d = (ground && !is_empty) ? 16'd1 : 16'd0;
      else if (ground && !is_empty && in_range)
        ground_cnt_d = sat_inc(ground_cnt_q);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ground_cnt_q <= '0;
    else     ground_cnt_q <= ground_cnt_d;
  end

  assign ground_cnt = ground_cnt_q;
`else
  assign ground_cnt = 16'd0;
`endif

  assign m_valid     = m_valid_q;
  assign m_row       = m_row_q;
  assign m_col       = m_col_q;
  assign m_x         = m_x_q;
  assign m_y         = m_y_q;
  assign m_z         = m_z_q;
  assign m_is_ground = m_gnd_q;
  assign frame_done  = frame_done_q;
  assign bad_idx     = bad_idx_q;

endmodule

// File: tb/tb_fcc_ground_seg.sv
// Scoreboard bench for fcc_ground_seg: stimulus pushes expected tagged points,
// a negedge monitor pops and compares on every output handoff.
module tb_fcc_ground_seg;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [7:0]         s_row = '0;
  logic [4:0]         s_col = '0;
  logic signed [15:0] s_x = '0, s_y = '0, s_z = '0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [7:0]         m_row;
  logic [4:0]         m_col;
  logic signed [15:0] m_x, m_y, m_z;
  logic               m_is_ground, frame_done, bad_idx;
  logic [15:0]        ground_cnt;

  fcc_ground_seg dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_row(s_row), .s_col(s_col),
    .s_x(s_x), .s_y(s_y), .s_z(s_z),
    .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row), .m_col(m_col),
    .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_is_ground(m_is_ground),
    .frame_done(frame_done), .bad_idx(bad_idx), .ground_cnt(ground_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]         row;
    logic [4:0]         col;
    logic signed [15:0] x, y, z;
    logic               g;
  } pt_t;

  pt_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  fd_seen = 0;
  bit  exp_fd = 1'b0;

  function automatic pt_t mk(int r, int c, int x, int y, int z, bit g);
    pt_t p;
    p.row = r[7:0];
    p.col = c[4:0];
    p.x   = x[15:0];
    p.y   = y[15:0];
    p.z   = z[15:0];
    p.g   = g;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Issue one point; returns #1 after the accepting edge
  task automatic send(input pt_t p);
    bit acc;
    int guard;
    exp_q.push_back(p);
    s_valid = 1'b1;
    s_row = p.row; s_col = p.col; s_x = p.x; s_y = p.y; s_z = p.z;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 300) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      guard++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    #1 s_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: compare every handoff against the scoreboard, track frame_done
  always @(negedge clk) begin
    pt_t got, e;
    if (rst) begin
      exp_fd = 1'b0;
    end else begin
      if (exp_fd || frame_done) chk("frame_done_pulse", frame_done, exp_fd);
      if (frame_done) fd_seen++;
      exp_fd = 1'b0;
      if (m_valid && m_ready) begin
        got.row = m_row; got.col = m_col; got.x = m_x; got.y = m_y; got.z = m_z;
        got.g = m_is_ground;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (got !== e) begin
            n_fail++;
            $display("FAIL point: got r%0d c%0d x%0d y%0d z%0d g%0b expected r%0d c%0d x%0d y%0d z%0d g%0b",
                     got.row, got.col, got.x, got.y, got.z, got.g,
                     e.row, e.col, e.x, e.y, e.z, e.g);
          end
        end
        if (m_row == 8'd29 && m_col == 5'd29) exp_fd = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_cnt;
    int z;
    bit g;
    pt_t a, b, c;

    // Test 1: reset state, then reset while a point is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_x", m_x, 0);
    chk("rst_gnd", m_is_ground, 0);
    chk("rst_bad_idx", bad_idx, 0);
    chk("rst_ground_cnt", ground_cnt, 0);
    chk("rst_s_ready", s_ready, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send(mk(0, 0, 1, 1, 1, 1));
    send(mk(0, 31, 1, 1, 1, 1));
    drain();
    chk("bad_idx_set", bad_idx, 1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    send(mk(1, 1, 2, 2, 2, 1));
`ifdef FCC_GSEG_STATS_EN
    chk("cnt_before_rst", ground_cnt, 2);
`else
    chk("cnt_before_rst", ground_cnt, 0);
`endif
    chk("held_valid", m_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_bad_idx", bad_idx, 0);
    chk("midrst_ground_cnt", ground_cnt, 0);
    exp_q.delete();
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 2: row 0 always ground, then z above Z_MAX
    send(mk(0, 5, 1, 1, 10, 1));
    send(mk(1, 5, 1, 1, 13, 0));
    // Test 3: slope 5 -> obstacle, slope 2 -> ground
    send(mk(3, 7, 1, 1, 5, 1));
    send(mk(4, 7, 1, 1, 10, 0));
    send(mk(5, 7, 1, 1, 8, 1));
    // Test 4: empty return leaves column invalid; slope boundaries
    send(mk(2, 2, 0, 0, 0, 1));
    send(mk(3, 2, 1, 1, 11, 1));
    send(mk(4, 2, 1, 1, 15, 0));
    send(mk(5, 2, 1, 1, 11, 1));
    send(mk(6, 2, 1, 1, 7, 1));
    send(mk(7, 2, 1, 1, 2, 0));
    send(mk(8, 2, 1, 1, -3, 0));
    send(mk(9, 2, 1, 1, -7, 1));
    send(mk(10, 3, 1, 1, 12, 1));
    send(mk(11, 3, 1, 1, 13, 0));
    // Empty row-0 return invalidates the column (else |10-2|=8 -> obstacle)
    send(mk(5, 9, 1, 1, 2, 1));
    send(mk(0, 9, 0, 0, 0, 1));
    send(mk(1, 9, 1, 1, 10, 1));
    drain();
    chk("bad_idx_clear", bad_idx, 0);

    // Test 5: downstream stall with input pending
    @(posedge clk); #1;
    m_ready = 1'b0;
    a = mk(6, 9, 7, -8, 9, 1);
    b = mk(7, 9, 3, 4, 11, 1);
    c = mk(8, 9, 5, 6, 20, 0);
    fork
      begin send(a); send(b); send(c); end
    join_none
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_s_ready", s_ready, 0);
      chk("stall_m_hold", {m_valid, m_row, m_x, m_y, m_z}, {1'b1, a.row, a.x[6:0], a.y, a.z});
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait fork;
    drain();

    // Test 6: full frame with an obstacle patch and a shallow bump
    @(posedge clk); #1;
    exp_cnt = 0;
    fd_seen = 0;
    for (int r = 0; r < 30; r++) begin
      for (int cc = 0; cc < 30; cc++) begin
        z = 0;
        if (r >= 10 && r <= 12 && cc >= 5 && cc <= 7) z = 20;
        if (r >= 20 && r <= 21 && cc >= 20 && cc <= 21) z = 10;
        g = !((r >= 10 && r <= 13 && cc >= 5 && cc <= 7) ||
              ((r == 20 || r == 22) && cc >= 20 && cc <= 21));
        if (g) exp_cnt++;
        send(mk(r, cc, cc + 1, r + 1, z, g));
      end
    end
    drain();
    repeat (2) @(negedge clk);
    chk("frame_done_count", fd_seen, 1);
    chk("frame_bad_idx", bad_idx, 0);
`ifdef FCC_GSEG_STATS_EN
    chk("frame_ground_cnt", ground_cnt, 884);
    chk("frame_ground_cnt_tbl", ground_cnt, exp_cnt);
`else
    chk("frame_ground_cnt", ground_cnt, 0);
`endif
    @(posedge clk); #1;
    send(mk(3, 31, 4, 4, 4, 1));
    drain();
    chk("bad_col_flag", bad_idx, 1);
`ifdef FCC_GSEG_STATS_EN
    chk("bad_col_cnt_hold", ground_cnt, 884);
`else
    chk("bad_col_cnt_hold", ground_cnt, 0);
`endif
    chk("frame_done_total", fd_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
